// File: rtl/core_pkg.sv
// Shared core-wide sizing defaults used when datapath blocks are instantiated.
package core_pkg;

    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_ADDR_W = 5;
    localparam int unsigned CORE_NUM_RD = 2;

    // Number of entries addressable by an address of the given width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, writing zero, then reports ready.
module regfile_clear_seq
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = CORE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int unsigned      DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              clr_we_q, clr_we_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            clr_we_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ready_q  <= ready_d;
            clr_we_q <= clr_we_d;
        end
    end

    // Pointer stops at the last entry instead of wrapping; RUN ignores it.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ready_d  = 1'b0;
        clr_we_d = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end else begin
                    ptr_d    = ptr_q + ADDR_W'(1);
                    clr_we_d = 1'b1;
                end
            end
            S_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d  = S_CLEAR;
                ptr_d    = '0;
                clr_we_d = 1'b1;
            end
        endcase
    end

    assign ready    = ready_q;
    assign clr_we   = clr_we_q;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: registered reads, single write port shared with
// the clear sequencer, optional write->read bypass and hardwired-zero entry 0.
module regfile_mp
    import core_pkg::*;
#(
    parameter int unsigned DATA_W   = CORE_DATA_W,
    parameter int unsigned ADDR_W   = CORE_ADDR_W,
    parameter int unsigned NUM_RD   = CORE_NUM_RD,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              usr_we_c;
    logic              arr_we_c;
    logic [ADDR_W-1:0] arr_waddr_c;
    logic [DATA_W-1:0] arr_wdata_c;
    logic [DATA_W-1:0] mem_q [DEPTH];

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User writes only land in RUN; entry 0 is read-only when hardwired to zero.
    assign usr_we_c = ready & wr_en & ~(ZERO_REG && (wr_addr == '0));

    always_comb begin
        arr_we_c    = 1'b0;
        arr_waddr_c = wr_addr;
        arr_wdata_c = wr_data;
        if (!rst) begin
            if (clr_we) begin
                arr_we_c    = 1'b1;
                arr_waddr_c = clr_addr;
                arr_wdata_c = '0;
            end else if (usr_we_c) begin
                arr_we_c = 1'b1;
            end
        end
    end

    // Storage is cleared by the sequencer, not by reset.
    always_ff @(posedge clk) begin
        if (arr_we_c) begin
            mem_q[arr_waddr_c] <= arr_wdata_c;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              accept_c;

        assign addr_c   = rd_addr[p*ADDR_W +: ADDR_W];
        assign accept_c = rd_en[p] & ready;

        // Zero entry wins over bypass, which wins over stored contents.
        always_comb begin
            data_d = mem_q[addr_c];
            if (BYPASS && usr_we_c && (wr_addr == addr_c)) begin
                data_d = wr_data;
            end
            if (ZERO_REG && (addr_c == '0)) begin
                data_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= accept_c;
                if (accept_c) begin
                    data_q <= data_d;
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_q;
        assign rd_valid[p]                 = valid_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypass/zero-reg instance and one plain instance
// driven by the same stimulus, each checked against hand-computed values.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic        ready_a, ready_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;

    int passed = 0;
    int total  = 0;
    int n;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_en = '0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        step();
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        chk("rst_valid_a", 64'(rd_valid_a), 64'd0);
        chk("rst_data_a", rd_data_a, 64'd0);
        chk("rst_data_b", rd_data_b, 64'd0);

        // 1: clear takes exactly DEPTH cycles; then every entry reads zero
        rst = 1'b0;
        n = 0;
        while (!ready_a && n < 100) begin step(); n++; end
        chk("ready_latency_a", 64'(n), 64'd32);
        chk("ready_b", 64'(ready_b), 64'd1);
        for (int i = 0; i < 32; i++) begin
            rd_en   = 2'b11;
            rd_addr = {5'(31 - i), 5'(i)};
            step();
            chk("clr_valid_a", 64'(rd_valid_a), 64'd3);
            chk("clr_data_a", rd_data_a, 64'd0);
            chk("clr_valid_b", 64'(rd_valid_b), 64'd3);
            chk("clr_data_b", rd_data_b, 64'd0);
        end
        rd_en = '0;

        // 2: write then read on port 0, port 1 idle keeps its data
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        step();
        chk("wr_rd_valid_a", 64'(rd_valid_a), 64'd1);
        chk("wr_rd_data_a", rd_data_a, {32'h0, 32'hDEADBEEF});
        chk("wr_rd_valid_b", 64'(rd_valid_b), 64'd1);
        chk("wr_rd_data_b", rd_data_b, {32'h0, 32'hDEADBEEF});
        rd_en = '0;
        step();
        chk("idle_valid_a", 64'(rd_valid_a), 64'd0);
        chk("idle_hold_a", rd_data_a, {32'h0, 32'hDEADBEEF});

        // 3: collision on entry 7
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
        step();
        wr_data = 32'h22222222; rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
        step();
        chk("coll_bypass_a", rd_data_a, {32'h22222222, 32'h22222222});
        chk("coll_old_b", rd_data_b, {32'h11111111, 32'h11111111});
        wr_en = 1'b0;
        step();
        chk("coll_after_a", rd_data_a, {32'h22222222, 32'h22222222});
        chk("coll_after_b", rd_data_b, {32'h22222222, 32'h22222222});

        // 4: entry 0 writes (dropped only on the zero-reg instance)
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0};
        step();
        chk("zero_same_a", rd_data_a, 64'd0);
        chk("zero_same_b", rd_data_b, 64'd0);
        wr_en = 1'b0;
        step();
        chk("zero_next_a", rd_data_a, 64'd0);
        chk("zero_next_b", rd_data_b, {32'hFFFFFFFF, 32'hFFFFFFFF});

        // 6: read coincident with reset is dropped and data cleared
        rd_en = 2'b11; rd_addr = {5'd5, 5'd7}; rst = 1'b1;
        step();
        chk("rstrd_valid_a", 64'(rd_valid_a), 64'd0);
        chk("rstrd_data_a", rd_data_a, 64'd0);
        chk("rstrd_valid_b", 64'(rd_valid_b), 64'd0);
        chk("rstrd_data_b", rd_data_b, 64'd0);
        chk("rstrd_ready_a", 64'(ready_a), 64'd0);

        // 5: reset 10 cycles into clear, write pulses throughout clear
        rst = 1'b0; rd_en = 2'b11;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i + 3); wr_data = 32'hA5A5A5A5;
            step();
            chk("clear_nordy_valid_a", 64'(rd_valid_a), 64'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (!ready_a && n < 100) begin
            wr_en = 1'b1; wr_addr = 5'(31 - n); wr_data = 32'h5A5A5A5A;
            step();
            n++;
        end
        wr_en = 1'b0;
        chk("ready_latency2_a", 64'(n), 64'd32);
        chk("ready2_b", 64'(ready_b), 64'd1);
        for (int i = 0; i < 32; i++) begin
            rd_en   = 2'b11;
            rd_addr = {5'(31 - i), 5'(i)};
            step();
            chk("reclr_data_a", rd_data_a, 64'd0);
            chk("reclr_data_b", rd_data_b, 64'd0);
        end
        rd_en = '0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
